// File: rtl/gen_seq_checker.sv
// gen_seq_checker: samples the generator's serial Y stream on a valid strobe,
// deserialises it into WIDTH-bit words (first bit in the MSB), detects a
// PLEN-bit pattern with overlap, and counts matches in a saturating counter.
module gen_seq_checker #(
    parameter int              WIDTH   = 8,
    parameter int              PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 'b1011,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             y_i,
    input  logic             y_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid,
    output logic             match_o,
    output logic [CNT_W-1:0] match_cnt,
    output logic [1:0]       state_o
);

    localparam int BIW = $clog2(WIDTH);
    localparam int FCW = $clog2(PLEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [PLEN-1:0]  r_hist;
    logic [WIDTH-1:0] r_wsr;
    logic [BIW-1:0]   r_bit_idx;
    logic [FCW-1:0]   r_fill_cnt;

    logic [PLEN-1:0]  w_hist_nxt;
    logic [WIDTH-1:0] w_wsr_nxt;
    logic             w_word_done;
    logic             w_run_nxt;
    logic             w_match;

    // Next-history/word values and the "history is full after this edge" flag.
    // The completing fill edge counts as RUN so its pattern can match.
    assign w_hist_nxt  = {r_hist[PLEN-2:0], y_i};
    assign w_wsr_nxt   = {r_wsr[WIDTH-2:0], y_i};
    assign w_word_done = (r_bit_idx == BIW'(WIDTH - 1));
    assign w_run_nxt   = (r_state == RUN) ||
                         ((r_state == FILL) && (r_fill_cnt == FCW'(PLEN - 1)));
    assign w_match     = w_run_nxt && (w_hist_nxt == PATTERN);

    assign state_o = r_state;

    // Sample path, fill FSM, registered pulses and saturating match counter.
    // NOTE: all state here uses non-blocking assignments so every register
    // sees pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_state    <= IDLE;
            r_hist     <= '0;
            r_wsr      <= '0;
            r_bit_idx  <= '0;
            r_fill_cnt <= '0;
            word_o     <= '0;
            word_valid <= 1'b0;
            match_o    <= 1'b0;
            match_cnt  <= '0;
        end else begin
            word_valid <= 1'b0;
            match_o    <= 1'b0;
            if (y_valid) begin
                r_hist <= w_hist_nxt;
                r_wsr  <= w_wsr_nxt;

                if (w_word_done) begin
                    word_o     <= w_wsr_nxt;
                    word_valid <= 1'b1;
                    r_bit_idx  <= '0;
                end else begin
                    r_bit_idx <= r_bit_idx + 1'b1;
                end

                case (r_state)
                    IDLE: begin
                        r_state    <= FILL;
                        r_fill_cnt <= FCW'(1);
                    end
                    FILL: begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                        if (r_fill_cnt == FCW'(PLEN - 1)) begin
                            r_state <= RUN;
                        end
                    end
                    RUN:     r_state <= RUN;
                    default: r_state <= IDLE;
                endcase

                if (w_match) begin
                    match_o <= 1'b1;
                    if (match_cnt != {CNT_W{1'b1}}) begin
                        match_cnt <= match_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gen_seq_checker.sv
// Directed bench for gen_seq_checker. Three instances share one stimulus:
// dut_a (defaults), dut_z (PATTERN=0000), dut_s (CNT_W=2).
module tb_gen_seq_checker;

    logic clk = 1'b0;
    logic rst;
    logic y_i;
    logic y_valid;
    logic clr;

    logic [7:0] a_word, z_word, s_word;
    logic       a_wv, z_wv, s_wv;
    logic       a_m, z_m, s_m;
    logic [7:0] a_cnt, z_cnt;
    logic [1:0] s_cnt;
    logic [1:0] a_st, z_st, s_st;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gen_seq_checker dut_a (
        .clk(clk), .rst(rst), .y_i(y_i), .y_valid(y_valid), .clr(clr),
        .word_o(a_word), .word_valid(a_wv), .match_o(a_m),
        .match_cnt(a_cnt), .state_o(a_st)
    );

    gen_seq_checker #(.PATTERN(4'b0000)) dut_z (
        .clk(clk), .rst(rst), .y_i(y_i), .y_valid(y_valid), .clr(clr),
        .word_o(z_word), .word_valid(z_wv), .match_o(z_m),
        .match_cnt(z_cnt), .state_o(z_st)
    );

    gen_seq_checker #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .y_i(y_i), .y_valid(y_valid), .clr(clr),
        .word_o(s_word), .word_valid(s_wv), .match_o(s_m),
        .match_cnt(s_cnt), .state_o(s_st)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one set of inputs across a rising edge; outputs sampled 1ns later.
    task automatic step(input logic v, input logic b, input logic c);
        y_valid = v;
        y_i     = b;
        clr     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
    endtask

    logic [15:0] sat_bits;
    logic [7:0]  word_bits;

    initial begin
        rst = 1'b1; y_i = 1'b0; y_valid = 1'b0; clr = 1'b0;
        #2;

        // Reset with y_valid active
        do_reset();
        check("rst_word",  a_word, 8'h00);
        check("rst_wv",    a_wv,   1'b0);
        check("rst_match", a_m,    1'b0);
        check("rst_cnt",   a_cnt,  8'h00);
        check("rst_state", a_st,   2'd0);
        check("rst_s_cnt", s_cnt,  2'd0);

        // Single match 1,0,1,1
        step(1'b1, 1'b1, 1'b0);
        check("sm_state_fill", a_st, 2'd1);
        check("sm_m1", a_m, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("sm_m2", a_m, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("sm_m3", a_m, 1'b0);
        check("sm_state_3", a_st, 2'd1);
        step(1'b1, 1'b1, 1'b0);
        check("sm_m4", a_m, 1'b1);
        check("sm_cnt", a_cnt, 8'd1);
        check("sm_state_run", a_st, 2'd2);
        step(1'b0, 1'b0, 1'b0);
        check("sm_m_drop", a_m, 1'b0);
        check("sm_cnt_hold", a_cnt, 8'd1);

        // Overlap with a 3-cycle gap after the 3rd bit
        step(1'b0, 1'b0, 1'b1);
        check("ov_clr_state", a_st, 2'd0);
        check("ov_clr_cnt", a_cnt, 8'd0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check("ov_gap_m", a_m, 1'b0);
            check("ov_gap_cnt", a_cnt, 8'd0);
            check("ov_gap_st", a_st, 2'd1);
        end
        step(1'b1, 1'b1, 1'b0);
        check("ov_m4", a_m, 1'b1);
        check("ov_cnt4", a_cnt, 8'd1);
        step(1'b1, 1'b0, 1'b0);
        check("ov_m5", a_m, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("ov_m6", a_m, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("ov_m7", a_m, 1'b1);
        check("ov_cnt7", a_cnt, 8'd2);

        // Word assembly: 1,0,1,0,0,1,1,1 -> A7, then eight zeros -> 00
        step(1'b0, 1'b0, 1'b1);
        word_bits = 8'b1010_0111;
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, word_bits[i], 1'b0);
            if (i != 0) begin
                check("wd_wv_low", a_wv, 1'b0);
                check("wd_word_hold0", a_word, 8'h00);
            end
        end
        check("wd_wv_a7", a_wv, 1'b1);
        check("wd_word_a7", a_word, 8'hA7);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i != 7) begin
                check("wd_wv_low2", a_wv, 1'b0);
                check("wd_word_holdA7", a_word, 8'hA7);
            end
        end
        check("wd_wv_00", a_wv, 1'b1);
        check("wd_word_00", a_word, 8'h00);
        step(1'b0, 1'b0, 1'b0);
        check("wd_wv_drop", a_wv, 1'b0);
        check("wd_word_keep", a_word, 8'h00);

        // Saturation on CNT_W=2: 1011 repeated with overlap, 5 matches
        step(1'b0, 1'b0, 1'b1);
        sat_bits = 16'b1011_0110_1101_1011;
        for (int i = 15; i >= 0; i--) begin
            step(1'b1, sat_bits[i], 1'b0);
            if (i == 6) check("sat_cnt_3rd", s_cnt, 2'd3);
        end
        check("sat_m_5th", s_m, 1'b1);
        check("sat_cnt_5th", s_cnt, 2'd3);
        check("sat_a_cnt", a_cnt, 8'd5);

        // clr with simultaneous valid bit: bit must be discarded
        step(1'b1, 1'b1, 1'b1);
        check("clr_s_cnt", s_cnt, 2'd0);
        check("clr_s_state", s_st, 2'd0);
        check("clr_s_m", s_m, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("clr_fill_st", s_st, 2'd1);
        check("clr_fill_m", s_m, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("clr_post_m", s_m, 1'b1);
        check("clr_post_cnt", s_cnt, 2'd1);
        check("clr_post_st", s_st, 2'd2);

        // Mid-stream reset with y_valid high
        do_reset();
        check("mrst_s_cnt", s_cnt, 2'd0);
        check("mrst_s_st", s_st, 2'd0);
        check("mrst_a_cnt", a_cnt, 8'd0);
        check("mrst_a_wv", a_wv, 1'b0);
        check("mrst_a_m", a_m, 1'b0);

        // Fill suppression with PATTERN=0000
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check("fz_no_match", z_m, 1'b0);
            check("fz_cnt0", z_cnt, 8'd0);
            check("fz_fill", z_st, 2'd1);
        end
        step(1'b1, 1'b0, 1'b0);
        check("fz_m4", z_m, 1'b1);
        check("fz_cnt4", z_cnt, 8'd1);
        check("fz_st4", z_st, 2'd2);
        step(1'b1, 1'b0, 1'b0);
        check("fz_m5", z_m, 1'b1);
        check("fz_cnt5", z_cnt, 8'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
